// File: rtl/packet_timer.sv
// Bit/byte/packet timer for the USB TX/RX paths: divides clk into bit periods and counts bits
// into bytes and bytes into packets. Define PACKET_TIMER_RESYNC_EN to realign on line edges.
// The line-transition input is named line_edge because "edge" is a SystemVerilog keyword.
module packet_timer #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned BYTE_BITS    = 8,
  parameter int unsigned SIZE_W       = 7,
  parameter int unsigned SAMPLE_PHASE = 3,
  localparam int unsigned BitW        = $clog2(BYTE_BITS),
  localparam int unsigned CntW        = $clog2(CLKS_PER_BIT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SIZE_W-1:0] packet_size,
  input  logic              abort,
  input  logic              stall,
  input  logic              line_edge,
  output logic              busy,
  output logic              bit_strobe,
  output logic              byte_done,
  output logic              packet_done,
  output logic [SIZE_W-1:0] byte_count,
  output logic [BitW-1:0]   bit_count
);

  typedef enum logic {StIdle, StRun} state_e;

  localparam logic [CntW-1:0] LastCnt   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] SampleCnt = CntW'(SAMPLE_PHASE);
  localparam logic [BitW-1:0] LastBit   = BitW'(BYTE_BITS - 1);

  state_e            state_q;
  logic [CntW-1:0]   clk_cnt_q;
  logic [SIZE_W-1:0] size_q;
  logic              bit_end;

  assign bit_end = (clk_cnt_q == LastCnt);

`ifndef PACKET_TIMER_RESYNC_EN
  logic unused_line_edge;
  assign unused_line_edge = line_edge;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      clk_cnt_q   <= '0;
      size_q      <= '0;
      busy        <= 1'b0;
      bit_strobe  <= 1'b0;
      byte_done   <= 1'b0;
      packet_done <= 1'b0;
      byte_count  <= '0;
      bit_count   <= '0;
    end else begin
      bit_strobe  <= 1'b0;
      byte_done   <= 1'b0;
      packet_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // abort is ignored here, so start always wins a same-cycle collision
          if (start) begin
            clk_cnt_q  <= '0;
            byte_count <= '0;
            bit_count  <= '0;
            if (packet_size == '0) begin
              packet_done <= 1'b1;
            end else begin
              size_q  <= packet_size;
              state_q <= StRun;
              busy    <= 1'b1;
            end
          end
        end
        StRun: begin
          if (abort) begin
            state_q    <= StIdle;
            busy       <= 1'b0;
            clk_cnt_q  <= '0;
            byte_count <= '0;
            bit_count  <= '0;
          end else begin
            bit_strobe <= (clk_cnt_q == SampleCnt);
            if (bit_end) begin
              clk_cnt_q <= '0;
              // a stalled bit-end is a stuff bit: the period elapses but nothing is counted
              if (!stall) begin
                if (bit_count == LastBit) begin
                  bit_count  <= '0;
                  byte_count <= byte_count + SIZE_W'(1);
                  byte_done  <= 1'b1;
                  if (byte_count + SIZE_W'(1) == size_q) begin
                    packet_done <= 1'b1;
                    state_q     <= StIdle;
                    busy        <= 1'b0;
                  end
                end else begin
                  bit_count <= bit_count + BitW'(1);
                end
              end
            end
`ifdef PACKET_TIMER_RESYNC_EN
            // the edge cycle itself counts as clk_cnt 0
            else if (line_edge) begin
              clk_cnt_q <= CntW'(1);
            end
`endif
            else begin
              clk_cnt_q <= clk_cnt_q + CntW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_timer.sv
// Self-checking bench for packet_timer: directed scenarios plus a randomized run, all checked
// against a timeline model that tracks cycles since start and bits counted.
module tb_packet_timer;

  localparam int CPB  = 8;
  localparam int BB   = 8;
  localparam int SW   = 7;
  localparam int SP   = 3;
  localparam int BITW = $clog2(BB);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [SW-1:0] packet_size = '0;
  logic          abort = 1'b0;
  logic          stall = 1'b0;
  logic          line_edge = 1'b0;
  logic          busy, bit_strobe, byte_done, packet_done;
  logic [SW-1:0] byte_count;
  logic [BITW-1:0] bit_count;

  packet_timer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .packet_size (packet_size),
    .abort       (abort),
    .stall       (stall),
    .line_edge   (line_edge),
    .busy        (busy),
    .bit_strobe  (bit_strobe),
    .byte_done   (byte_done),
    .packet_done (packet_done),
    .byte_count  (byte_count),
    .bit_count   (bit_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference model: m_trel = cycles since the accepted start, m_bits = bits counted so far.
  bit m_run  = 1'b0;
  int m_trel = 0;
  int m_bits = 0;
  int m_size = 0;
  bit e_busy = 1'b0, e_strobe = 1'b0, e_bdone = 1'b0, e_pdone = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step();
    e_strobe = 1'b0;
    e_bdone  = 1'b0;
    e_pdone  = 1'b0;
    if (rst) begin
      m_run  = 1'b0;
      m_bits = 0;
      e_busy = 1'b0;
    end else if (!m_run) begin
      if (start) begin
        m_bits = 0;
        if (packet_size == 0) begin
          e_pdone = 1'b1;
        end else begin
          m_run  = 1'b1;
          m_size = int'(packet_size);
          m_trel = 1;
          e_busy = 1'b1;
        end
      end
    end else if (abort) begin
      m_run  = 1'b0;
      m_bits = 0;
      e_busy = 1'b0;
    end else begin
      e_strobe = ((m_trel % CPB) == ((SP + 1) % CPB));
      if (m_trel % CPB == 0) begin
        if (!stall) begin
          m_bits++;
          if (m_bits % BB == 0) e_bdone = 1'b1;
          if (m_bits == BB * m_size) begin
            e_pdone = 1'b1;
            m_run   = 1'b0;
            e_busy  = 1'b0;
          end
        end
      end
`ifdef PACKET_TIMER_RESYNC_EN
      else if (line_edge) begin
        m_trel = m_trel - (m_trel % CPB) + 1;
      end
`endif
      m_trel++;
    end
  endtask

  task automatic check_model();
    chk("busy", 32'(busy), 32'(e_busy));
    chk("bit_strobe", 32'(bit_strobe), 32'(e_strobe));
    chk("byte_done", 32'(byte_done), 32'(e_bdone));
    chk("packet_done", 32'(packet_done), 32'(e_pdone));
    chk("byte_count", 32'(byte_count), 32'(m_bits / BB));
    chk("bit_count", 32'(bit_count), 32'(m_bits % BB));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check_model();
  endtask

  task automatic quiet();
    start     = 1'b0;
    abort     = 1'b0;
    stall     = 1'b0;
    line_edge = 1'b0;
  endtask

  task automatic launch(input int size);
    start       = 1'b1;
    packet_size = SW'(size);
    cyc         = 0;
    tick();
    start = 1'b0;
  endtask

  int first_strobe, bd_cycle;

  initial begin
    // reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_byte_count", 32'(byte_count), 0);
    chk("rst_bit_count", 32'(bit_count), 0);
    chk("rst_pulses", {29'd0, bit_strobe, byte_done, packet_done}, 0);
    rst = 1'b0;
    tick();

    // two-byte packet; start and packet_size wiggle while running and must be ignored
    launch(2);
    while (cyc < 140) begin
      chk("s2_strobe", 32'(bit_strobe), 32'(cyc >= 5 && cyc <= 125 && (cyc - 5) % 8 == 0));
      chk("s2_byte_done", 32'(byte_done), 32'(cyc == 65 || cyc == 129));
      chk("s2_packet_done", 32'(packet_done), 32'(cyc == 129));
      chk("s2_busy", 32'(busy), 32'(cyc >= 1 && cyc <= 128));
      if (cyc < 120) begin
        start       = 1'($urandom_range(0, 1));
        packet_size = SW'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk("s2_final_bytes", 32'(byte_count), 2);

    // one-byte packet with a stuff bit on the third bit-end
    launch(1);
    while (cyc < 90) begin
      if (cyc == 25) chk("s3_bits_after_stall", 32'(bit_count), 2);
      if (cyc == 33) chk("s3_bits_next", 32'(bit_count), 3);
      if (cyc == 72) chk("s3_bits_last", 32'(bit_count), 7);
      chk("s3_byte_done", 32'(byte_done), 32'(cyc == 73));
      chk("s3_packet_done", 32'(packet_done), 32'(cyc == 73));
      stall = (cyc == 24);
      tick();
    end
    quiet();

    // three-byte packet aborted in cycle 70
    launch(3);
    while (cyc < 300) begin
      if (cyc == 71) begin
        chk("s4_busy", 32'(busy), 0);
        chk("s4_byte_count", 32'(byte_count), 0);
        chk("s4_bit_count", 32'(bit_count), 0);
      end
      if (cyc >= 71) chk("s4_no_pulses", {30'd0, byte_done, packet_done}, 0);
      abort = (cyc == 70);
      tick();
    end
    quiet();

    // zero-length packet
    launch(0);
    while (cyc < 10) begin
      chk("s5_packet_done", 32'(packet_done), 32'(cyc == 1));
      chk("s5_busy", 32'(busy), 0);
      tick();
    end

    // permanent stall, then a one-cycle reset
    stall = 1'b1;
    launch(1);
    while (cyc < 500) begin
      chk("s6_no_byte_done", 32'(byte_done), 0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    stall = 1'b0;
    chk("s6_rst_busy", 32'(busy), 0);
    chk("s6_rst_counts", 32'({byte_count, bit_count}), 0);
    chk("s6_rst_pulses", {29'd0, bit_strobe, byte_done, packet_done}, 0);
    tick();

    // line edge in cycle 3
`ifdef PACKET_TIMER_RESYNC_EN
    first_strobe = 7;
    bd_cycle     = 67;
`else
    first_strobe = 5;
    bd_cycle     = 65;
`endif
    launch(1);
    while (cyc < 80) begin
      chk("s7_strobe", 32'(bit_strobe), 32'(cyc >= first_strobe &&
          cyc <= first_strobe + 56 && (cyc - first_strobe) % 8 == 0));
      chk("s7_byte_done", 32'(byte_done), 32'(cyc == bd_cycle));
      line_edge = (cyc == 3);
      tick();
    end
    quiet();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 999) == 0);
      start       = ($urandom_range(0, 7) == 0);
      packet_size = SW'($urandom_range(0, 3));
      abort       = ($urandom_range(0, 199) == 0);
      stall       = ($urandom_range(0, 5) == 0);
      line_edge   = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/packet_timer.md
# packet_timer

Parametrised bit/byte/packet timer for the USB transmit and receive paths. It divides the system clock into bit periods and counts bits into bytes and bytes into packets. It also adds a mid-bit sample strobe, bit-stuff stalls, abort, zero-length packets and optional edge resynchronisation. The block sits between the TX/RX control FSMs and the shift registers and replaces fixed cascaded divide-by-8 counting.

## Interface
- CLKS_PER_BIT, 8, clocks per USB bit period (≥2)
- BYTE_BITS, 8, bits per byte (≥2)
- SIZE_W, 7, width of packet_size and byte_count
- SAMPLE_PHASE, 3, clk_cnt value at which bit_strobe fires (0..CLKS_PER_BIT-1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a packet; sampled only in IDLE
- packet_size  in  SIZE_W  byte count of the packet; latched on accepted start
- abort  in  1  terminate the packet immediately; no done pulses
- stall  in  1  sampled at bit-end; when high, the current bit is a stuff bit and is not counted
- edge  in  1  line transition, used for resync (see Configuration)
- busy  out  1  high in RUN
- bit_strobe  out  1  one-cycle pulse at the sample point of each bit
- byte_done  out  1  one-cycle pulse after the last bit of each byte
- packet_done  out  1  one-cycle pulse when the packet completes
- byte_count  out  SIZE_W  bytes completed in the current packet
- bit_count  out  $clog2(BYTE_BITS)  bits completed in the current byte

## Operation
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- States: IDLE, RUN. Internal clk_cnt counts 0..CLKS_PER_BIT-1 in RUN and is held at 0 in IDLE.
- IDLE with start=1 and packet_size≠0: latch size, clear counters, go to RUN.
- IDLE with start=1 and packet_size=0: stay in IDLE, pulse packet_done next cycle, no byte_done.
- RUN: clk_cnt increments each cycle. bit_strobe is registered high the cycle after clk_cnt==SAMPLE_PHASE.
- Bit-end is the cycle with clk_cnt==CLKS_PER_BIT-1. clk_cnt wraps to 0.
  - stall=1 at bit-end: no counter changes.
  - Otherwise bit_count increments.
  - If bit_count==BYTE_BITS-1: bit_count←0, byte_count increments, byte_done pulses.
  - If the new byte_count equals the latched size: packet_done pulses, state←IDLE, clk_cnt←0.
- start in RUN is ignored. packet_size changes after latch have no effect.
- abort in RUN: next cycle state=IDLE, all counters 0. abort suppresses any byte_done/packet_done that would coincide.
- abort in IDLE has no effect. If abort and start arrive in the same IDLE cycle, start wins.
- Priority: rst > abort > bit-end processing > resync.
- byte_count and bit_count hold their final values in IDLE until the next accepted start or abort.

## Timing
- Reset values: busy=0, bit_strobe=0, byte_done=0, packet_done=0, byte_count=0, bit_count=0, state IDLE.
- All outputs are registered.
- Cycle numbering for the defaults: start is sampled at edge 0.
  - busy=1 from cycle 1; clk_cnt=0 in cycle 1.
  - bit_strobe is high in cycles 5, 13, 21, …
  - First bit-end is cycle 8.
  - byte_done is high in cycle 65 for byte 1, cycle 129 for byte 2, ….
  - An N-byte packet gives packet_done=1 and busy=0 in cycle 64N+1, together with that byte's byte_done.
- Each stalled bit adds exactly CLKS_PER_BIT cycles. bit_strobe still fires for a stuff bit.
- Zero-length packets: packet_done is high in cycle 1 and busy stays 0.
- A new start is accepted in the same cycle that packet_done is high (state is IDLE).

## Configuration
- PACKET_TIMER_RESYNC_EN defined:
  - In RUN, edge=1 forces clk_cnt←1 next cycle, i.e. the edge cycle counts as clk_cnt 0.
  - This does not apply on a bit-end cycle: bit-end takes priority, and clk_cnt wraps normally.
  - bit_strobe timing follows the realigned clk_cnt.
- Not defined: edge is ignored and clk_cnt free-runs within RUN. The port remains present.

## Test plan
- Reset then start with packet_size=2 (defaults), no stall:
  - bit_strobe in cycles 5+8k.
  - byte_done in cycles 65 and 129.
  - packet_done and busy falling in cycle 129.
  - byte_count=2 afterwards.
- packet_size=1 with stall=1 at the 3rd bit-end (cycle 24): byte_done and packet_done move to cycle 73, and bit_count skips no value.
- packet_size=3 with abort in cycle 70: busy=0 in cycle 71, counters 0, and no further pulses.
- start with packet_size=0: packet_done is high in cycle 1 only, and busy never rises.
- start with packet_size=1 while stall is held high permanently: no byte_done through 500 cycles. Then rst for one cycle: all outputs 0 next cycle.
- With PACKET_TIMER_RESYNC_EN, edge in cycle 3: the next bit_strobe is in cycle 7 and the first bit-end is in cycle 10. Without the macro, the timing is unchanged from the first scenario.
